// File: rtl/spec_acc_sequencer_if.sv
// Bundle of the command, sample-stream, DPRAM and readout signals of the
// spectrum accumulation sequencer. The master modport is the sequencer's view.
// The slave modport is the view of the surrounding host, ADC and DPRAM logic.
interface spec_acc_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  // host commands
  logic              start;
  logic              abort;
  logic [15:0]       pulse_total;
  // sample stream
  logic              trig;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  // DPRAM ports
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ACC_W-1:0]  wr_data;
  // status and readout handshake
  logic              capture_en;
  logic              acc_ctrl;
  logic              busy;
  logic [15:0]       pulse_cnt;
  logic              rdout_req;
  logic              rdout_ack;
  logic              done;
  logic              trig_miss;
  logic              sat_flag;

  modport master (
    input  start, abort, pulse_total, trig, din_valid, din, rd_data, rdout_ack,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, capture_en, acc_ctrl,
           busy, pulse_cnt, rdout_req, done, trig_miss, sat_flag
  );

  modport slave (
    output start, abort, pulse_total, trig, din_valid, din, rd_data, rdout_ack,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, capture_en, acc_ctrl,
           busy, pulse_cnt, rdout_req, done, trig_miss, sat_flag
  );
endinterface

// File: rtl/spec_acc_sequencer.sv
// Multi-pulse spectrum accumulation sequencer.
// Each pulse of a group is captured after a trigger and streamed through a
// read-modify-write pipeline into the spectrum DPRAM. The first pulse
// overwrites the bins and later pulses add to them with saturation. At the
// end of the group the DPRAM is handed to the readout side via rdout_req/ack.
module spec_acc_sequencer #(
  parameter int NBINS  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  spec_acc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_ACQ     = 3'd2,
    S_FLUSH   = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NBINS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] bin_q;
  logic              pend_q;       // a held sample waits for its write
  logic [ADDR_W-1:0] hold_bin_q;
  logic [DATA_W-1:0] hold_din_q;
  logic [15:0]       total_q;
  logic [15:0]       pulse_cnt_q;
  logic              capture_en_q;
  logic              acc_ctrl_q;
  logic              busy_q;
  logic              rdout_req_q;
  logic              done_q;
  logic              trig_miss_q;
  logic              sat_flag_q;

  logic [ACC_W-1:0]  din_ext_s;
  logic [ACC_W:0]    sum_s;
  logic [ACC_W-1:0]  wr_data_d;
  logic              sat_s;
  logic [15:0]       pulse_cnt_inc_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Write data: overwrite on the first pulse, saturating add afterwards.
  always_comb begin
    din_ext_s       = {{(ACC_W-DATA_W){1'b0}}, hold_din_q};
    sum_s           = {1'b0, bus.rd_data} + {1'b0, din_ext_s};
    sat_s           = 1'b0;
    wr_data_d       = {ACC_W{1'b0}};
    pulse_cnt_inc_s = pulse_cnt_q + 16'd1;
    if (pend_q) begin
      if (pulse_cnt_q == 16'd0) begin
        wr_data_d = din_ext_s;
      end else if (sum_s[ACC_W]) begin
        wr_data_d = {ACC_W{1'b1}};
        sat_s     = 1'b1;
      end else begin
        wr_data_d = sum_s[ACC_W-1:0];
      end
    end else begin
      wr_data_d = {ACC_W{1'b0}};
    end
  end

  // Read port follows the bin counter directly so rd_data lines up with the held sample.
  always_comb begin
    rd_en_s   = 1'b0;
    rd_addr_s = {ADDR_W{1'b0}};
    if (state_q == S_ACQ) begin
      rd_en_s   = bus.din_valid;
      rd_addr_s = bin_q;
    end else begin
      rd_en_s   = 1'b0;
      rd_addr_s = {ADDR_W{1'b0}};
    end
  end

  // Sequencer FSM with the sample pipeline and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bin_q        <= {ADDR_W{1'b0}};
      pend_q       <= 1'b0;
      hold_bin_q   <= {ADDR_W{1'b0}};
      hold_din_q   <= {DATA_W{1'b0}};
      total_q      <= 16'd0;
      pulse_cnt_q  <= 16'd0;
      capture_en_q <= 1'b0;
      acc_ctrl_q   <= 1'b0;
      busy_q       <= 1'b0;
      rdout_req_q  <= 1'b0;
      done_q       <= 1'b0;
      trig_miss_q  <= 1'b0;
      sat_flag_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The write issued this cycle may saturate; a start in IDLE clears it below.
      if (pend_q && sat_s) begin
        sat_flag_q <= 1'b1;
      end
      if (bus.abort) begin
        state_q      <= S_IDLE;
        bin_q        <= {ADDR_W{1'b0}};
        pend_q       <= 1'b0;
        capture_en_q <= 1'b0;
        acc_ctrl_q   <= 1'b0;
        busy_q       <= 1'b0;
        rdout_req_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            pend_q <= 1'b0;
            if (bus.start) begin
              state_q      <= S_ARM;
              total_q      <= (bus.pulse_total == 16'd0) ? 16'd1 : bus.pulse_total;
              pulse_cnt_q  <= 16'd0;
              trig_miss_q  <= 1'b0;
              sat_flag_q   <= 1'b0;
              capture_en_q <= 1'b1;
              acc_ctrl_q   <= 1'b0;
              busy_q       <= 1'b1;
            end
          end
          S_ARM: begin
            bin_q  <= {ADDR_W{1'b0}};
            pend_q <= 1'b0;
            if (bus.trig) begin
              state_q <= S_ACQ;
            end
          end
          S_ACQ: begin
            if (bus.trig) begin
              trig_miss_q <= 1'b1;
            end
            pend_q <= bus.din_valid;
            if (bus.din_valid) begin
              hold_bin_q <= bin_q;
              hold_din_q <= bus.din;
              bin_q      <= bin_q + ADDR_W'(1);
              if (bin_q == LAST_BIN) begin
                state_q      <= S_FLUSH;
                capture_en_q <= 1'b0;
              end
            end
          end
          S_FLUSH: begin
            if (bus.trig) begin
              trig_miss_q <= 1'b1;
            end
            pend_q      <= 1'b0;
            pulse_cnt_q <= pulse_cnt_inc_s;
            acc_ctrl_q  <= (pulse_cnt_inc_s != 16'd0);
            if (pulse_cnt_inc_s == total_q) begin
              state_q     <= S_READOUT;
              rdout_req_q <= 1'b1;
            end else begin
              state_q      <= S_ARM;
              capture_en_q <= 1'b1;
            end
          end
          S_READOUT: begin
            pend_q <= 1'b0;
            if (bus.rdout_ack) begin
              state_q     <= S_IDLE;
              done_q      <= 1'b1;
              rdout_req_q <= 1'b0;
              busy_q      <= 1'b0;
              acc_ctrl_q  <= 1'b0;
            end
          end
          default: begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            capture_en_q <= 1'b0;
            busy_q       <= 1'b0;
            rdout_req_q  <= 1'b0;
            acc_ctrl_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_en      = rd_en_s;
  assign bus.rd_addr    = rd_addr_s;
  assign bus.wr_en      = pend_q;
  assign bus.wr_addr    = pend_q ? hold_bin_q : {ADDR_W{1'b0}};
  assign bus.wr_data    = wr_data_d;
  assign bus.capture_en = capture_en_q;
  assign bus.acc_ctrl   = acc_ctrl_q;
  assign bus.busy       = busy_q;
  assign bus.pulse_cnt  = pulse_cnt_q;
  assign bus.rdout_req  = rdout_req_q;
  assign bus.done       = done_q;
  assign bus.trig_miss  = trig_miss_q;
  assign bus.sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_spec_acc_sequencer.sv
// Directed bench for spec_acc_sequencer with a small DPRAM model and a write scoreboard.
module tb_spec_acc_sequencer;
  localparam int NBINS  = 4;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 17;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ACC_W-1:0]  data;
  } wr_t;

  logic clk;
  logic rst;
  spec_acc_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus_if ();

  spec_acc_sequencer #(.NBINS(NBINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  wr_t               exp_q[$];
  wr_t               got;
  int                checks   = 0;
  int                passed   = 0;
  int                wr_count = 0;
  int                wr_base;
  logic [ACC_W-1:0]  mem   [0:(1<<ADDR_W)-1];
  logic [ACC_W-1:0]  model [0:NBINS-1];
  logic              prev_rd_en;
  logic [ADDR_W-1:0] prev_rd_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // DPRAM model: registered read, write on the clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
      bus_if.rd_data <= '0;
    end else begin
      if (bus_if.rd_en) bus_if.rd_data <= mem[bus_if.rd_addr];
      if (bus_if.wr_en) mem[bus_if.wr_addr] <= bus_if.wr_data;
    end
  end

  // Write monitor: pops the scoreboard and checks the read one cycle earlier.
  always @(negedge clk) begin
    if (rst) begin
      prev_rd_en   <= 1'b0;
      prev_rd_addr <= '0;
    end else begin
      if (bus_if.wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          chk("write_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          got = exp_q.pop_front();
          chk("wr_addr", 64'(bus_if.wr_addr), 64'(got.addr));
          chk("wr_data", 64'(bus_if.wr_data), 64'(got.data));
        end
        chk("rd_before_wr", 64'({prev_rd_en, prev_rd_addr}), 64'({1'b1, bus_if.wr_addr}));
      end
      prev_rd_en   <= bus_if.rd_en;
      prev_rd_addr <= bus_if.rd_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk(tag, 64'({bus_if.rd_en, bus_if.rd_addr, bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data,
                  bus_if.capture_en, bus_if.acc_ctrl, bus_if.busy, bus_if.pulse_cnt,
                  bus_if.rdout_req, bus_if.done, bus_if.trig_miss, bus_if.sat_flag}), 64'd0);
  endtask

  task automatic do_start(input logic [15:0] total);
    bus_if.start       = 1'b1;
    bus_if.pulse_total = total;
    tick();
    bus_if.start       = 1'b0;
    bus_if.pulse_total = 16'd0;
    chk("start_busy", 64'(bus_if.busy), 64'd1);
    chk("start_capture", 64'(bus_if.capture_en), 64'd1);
    chk("start_pulse_cnt", 64'(bus_if.pulse_cnt), 64'd0);
  endtask

  // Drive one sample and push the write it must produce.
  task automatic push_sample(input int p, input int b, input logic [DATA_W-1:0] v);
    logic [ACC_W:0] s;
    wr_t e;
    if (p == 0) begin
      model[b] = {{(ACC_W-DATA_W){1'b0}}, v};
    end else begin
      s = {1'b0, model[b]} + (ACC_W+1)'(v);
      model[b] = (s > {1'b0, ACC_MAX}) ? ACC_MAX : s[ACC_W-1:0];
    end
    e.addr = ADDR_W'(b);
    e.data = model[b];
    exp_q.push_back(e);
    bus_if.din_valid = 1'b1;
    bus_if.din       = v;
    tick();
    bus_if.din_valid = 1'b0;
    bus_if.din       = '0;
  endtask

  // From ARM: trigger, stream NBINS samples, pass through FLUSH.
  task automatic run_pulse(input int p, input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] step,
                           input bit gaps, input bit trig_mid);
    bus_if.trig = 1'b1;
    tick();
    bus_if.trig = 1'b0;
    chk("acq_capture", 64'(bus_if.capture_en), 64'd1);
    chk("acq_acc_ctrl", 64'(bus_if.acc_ctrl), 64'(p != 0));
    for (int b = 0; b < NBINS; b++) begin
      if (gaps) begin
        bus_if.trig = trig_mid && (b == 2);
        tick();
        bus_if.trig = 1'b0;
      end
      push_sample(p, b, DATA_W'(base + DATA_W'(b) * step));
    end
    chk("flush_capture", 64'(bus_if.capture_en), 64'd0);
    chk("flush_pulse_cnt", 64'(bus_if.pulse_cnt), 64'(p));
    tick();
  endtask

  task automatic finish_readout(input logic [15:0] final_cnt);
    chk("readout_req", 64'(bus_if.rdout_req), 64'd1);
    chk("readout_cnt", 64'(bus_if.pulse_cnt), 64'(final_cnt));
    bus_if.rdout_ack = 1'b1;
    tick();
    bus_if.rdout_ack = 1'b0;
    chk("done_pulse", 64'({bus_if.done, bus_if.rdout_req, bus_if.busy, bus_if.acc_ctrl}), 64'b1000);
    tick();
    chk("done_clear", 64'(bus_if.done), 64'd0);
    chk("final_cnt_hold", 64'(bus_if.pulse_cnt), 64'(final_cnt));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.abort       = 1'b0;
    bus_if.pulse_total = 16'd0;
    bus_if.trig        = 1'b0;
    bus_if.din_valid   = 1'b0;
    bus_if.din         = '0;
    bus_if.rdout_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // single pulse, ramp data, overwrite mode
    wr_base = wr_count;
    do_start(16'd1);
    chk("a_acc_ctrl", 64'(bus_if.acc_ctrl), 64'd0);
    run_pulse(0, 16'd10, 16'd10, 1'b0, 1'b0);
    bus_if.din_valid = 1'b1;
    #1;
    chk("readout_no_access", 64'({bus_if.rd_en, bus_if.wr_en, bus_if.capture_en}), 64'd0);
    bus_if.din_valid = 1'b0;
    chk("a_mem3", 64'(mem[3]), 64'd40);
    finish_readout(16'd1);
    chk("a_writes", 64'(wr_count - wr_base), 64'd4);

    // three pulses of 5 accumulate to 15
    wr_base = wr_count;
    do_start(16'd3);
    run_pulse(0, 16'd5, 16'd0, 1'b0, 1'b0);
    chk("b_rearm", 64'({bus_if.capture_en, bus_if.rdout_req, bus_if.pulse_cnt}), 64'({1'b1, 1'b0, 16'd1}));
    run_pulse(1, 16'd5, 16'd0, 1'b0, 1'b0);
    run_pulse(2, 16'd5, 16'd0, 1'b0, 1'b0);
    for (int b = 0; b < NBINS; b++) chk("b_bin15", 64'(mem[b]), 64'd15);
    finish_readout(16'd3);
    chk("b_writes", 64'(wr_count - wr_base), 64'd12);

    // saturation on the third pulse
    do_start(16'd3);
    run_pulse(0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    run_pulse(1, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    chk("c_no_sat_yet", 64'(bus_if.sat_flag), 64'd0);
    run_pulse(2, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    chk("c_sat_flag", 64'(bus_if.sat_flag), 64'd1);
    chk("c_sat_value", 64'(mem[0]), 64'h1FFFF);
    finish_readout(16'd3);

    // valid gaps plus a stray trigger inside ACQ
    wr_base = wr_count;
    do_start(16'd1);
    chk("d_sat_cleared", 64'({bus_if.sat_flag, bus_if.trig_miss}), 64'd0);
    run_pulse(0, 16'd7, 16'd1, 1'b1, 1'b1);
    chk("d_trig_miss", 64'(bus_if.trig_miss), 64'd1);
    chk("d_overwrite", 64'(mem[0]), 64'd7);
    finish_readout(16'd1);
    chk("d_writes", 64'(wr_count - wr_base), 64'd4);

    // abort during pulse 2 of 3
    wr_base = wr_count;
    do_start(16'd3);
    chk("e_trig_miss_clr", 64'(bus_if.trig_miss), 64'd0);
    run_pulse(0, 16'd1, 16'd1, 1'b0, 1'b0);
    bus_if.trig = 1'b1;
    tick();
    bus_if.trig = 1'b0;
    push_sample(1, 0, 16'd100);
    push_sample(1, 1, 16'd200);
    tick();
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    chk("e_abort_idle", 64'({bus_if.busy, bus_if.capture_en, bus_if.rdout_req, bus_if.done, bus_if.acc_ctrl}), 64'd0);
    chk("e_cnt_hold", 64'(bus_if.pulse_cnt), 64'd1);
    bus_if.din_valid = 1'b1;
    bus_if.trig      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("e_idle_no_access", 64'({bus_if.rd_en, bus_if.wr_en, bus_if.done, bus_if.busy}), 64'd0);
      tick();
    end
    bus_if.din_valid = 1'b0;
    bus_if.trig      = 1'b0;
    chk("e_idle_trig_ignored", 64'(bus_if.trig_miss), 64'd0);
    bus_if.rdout_ack = 1'b1;
    tick();
    bus_if.rdout_ack = 1'b0;
    chk("e_ack_in_idle", 64'({bus_if.done, bus_if.busy}), 64'd0);
    chk("e_writes", 64'(wr_count - wr_base), 64'd6);
    chk("e_queue_empty", 64'(exp_q.size()), 64'd0);

    // pulse_total 0 acts as 1; start while busy is ignored
    do_start(16'd0);
    bus_if.start       = 1'b1;
    bus_if.pulse_total = 16'd5;
    tick();
    bus_if.start       = 1'b0;
    bus_if.pulse_total = 16'd0;
    chk("f_start_in_arm", 64'({bus_if.capture_en, bus_if.pulse_cnt}), 64'({1'b1, 16'd0}));
    run_pulse(0, 16'd3, 16'd2, 1'b0, 1'b0);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    chk("f_start_in_readout", 64'({bus_if.rdout_req, bus_if.capture_en}), 64'b10);
    finish_readout(16'd1);

    // asynchronous reset in the middle of ACQ
    do_start(16'd2);
    bus_if.trig = 1'b1;
    tick();
    bus_if.trig = 1'b0;
    push_sample(0, 0, 16'd11);
    bus_if.din_valid = 1'b1;
    bus_if.din       = 16'd22;
    tick();
    chk("g_wr_pending", 64'(bus_if.wr_en), 64'd1);
    rst = 1'b1;
    #1;
    check_zero("g_async_reset");
    exp_q.delete();
    bus_if.din_valid = 1'b0;
    bus_if.din       = '0;
    tick();
    rst = 1'b0;
    tick();
    check_zero("g_after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spec_acc_sequencer.md
Name: spec_acc_sequencer

Overview:
Sequences multi-pulse spectrum accumulation into the spectrum DPRAM. For each pulse in a group it arms capture, waits for a trigger, and streams NBINS samples through a read-modify-write pipeline. The first pulse overwrites the bins; later pulses add to them. After the last pulse it hands the DPRAM to the readout side through a req/ack handshake. It sits between the host command registers, the ADC sample stream and the spectrum DPRAM ports.

Parameters:
NBINS, 1024, bins per pulse (samples per trigger); must be >= 2
ADDR_W, 10, DPRAM address width; 2^ADDR_W >= NBINS
DATA_W, 16, input sample width (unsigned)
ACC_W, 32, DPRAM word / accumulator width; ACC_W > DATA_W

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle group start command
abort  in  1  one-cycle abort command
pulse_total  in  16  pulses per group, latched on accepted start
trig  in  1  one-cycle pulse trigger
din_valid  in  1  sample valid
din  in  DATA_W  sample
rd_en  out  1  DPRAM read enable
rd_addr  out  ADDR_W  DPRAM read address
rd_data  in  ACC_W  DPRAM read data, 1-cycle latency after rd_en
wr_en  out  1  DPRAM write enable
wr_addr  out  ADDR_W  DPRAM write address
wr_data  out  ACC_W  DPRAM write data
capture_en  out  1  high in ARM and ACQ
acc_ctrl  out  1  high while the current pulse index is > 0 (accumulate mode)
busy  out  1  high in any state other than IDLE
pulse_cnt  out  16  pulses completed in the current group
rdout_req  out  1  DPRAM is owned by the readout side
rdout_ack  in  1  readout finished
done  out  1  one-cycle pulse on the cycle rdout_ack is accepted
trig_miss  out  1  sticky: trig seen while in ACQ or FLUSH; cleared on accepted start
sat_flag  out  1  sticky: a bin saturated; cleared on accepted start

Behaviour:
- Reset: state IDLE. All outputs 0, including the addresses and wr_data.
- States: IDLE, ARM, ACQ, FLUSH, READOUT.
- IDLE:
  - start -> ARM. On the same edge: latch pulse_total (0 treated as 1), pulse_cnt <= 0, clear trig_miss and sat_flag.
  - start while busy is ignored.
- ARM: trig -> ACQ on the next edge. The bin counter resets to 0.
- ACQ:
  - Each cycle with din_valid: rd_en=1, rd_addr=bin (combinational from state and bin counter), then bin increments.
  - din is held one cycle. On the next cycle: wr_en=1, wr_addr = held bin.
  - wr_data = zero-extended held din when pulse_cnt==0; otherwise rd_data + held din.
  - Accumulation saturates at 2^ACC_W-1 and sets sat_flag.
  - din_valid gaps stall the pipeline; no write occurs for a gap.
  - After accepting bin NBINS-1 -> FLUSH.
- FLUSH (one cycle):
  - The final write is issued.
  - pulse_cnt increments.
  - If the new pulse_cnt == latched total -> READOUT; else -> ARM.
- Address ordering: no read-after-write hazard. Consecutive addresses differ and NBINS >= 2, so the last write of pulse p precedes the bin-0 read of pulse p+1.
- READOUT:
  - rdout_req=1, no DPRAM accesses.
  - On rdout_ack: done=1 for one cycle, rdout_req drops, -> IDLE. pulse_cnt holds its final value.
- acc_ctrl is registered and equals (pulse_cnt != 0) while busy; 0 in IDLE.
- Inputs ignored by state:
  - trig in IDLE, READOUT: ignored.
  - trig in ACQ, FLUSH: ignored, sets trig_miss.
  - din_valid outside ACQ: ignored.
  - rdout_ack outside READOUT: ignored.
- abort:
  - Any state -> IDLE next edge. Clears rd_en, wr_en, rdout_req, bin counter.
  - No done pulse. pulse_cnt and flags hold.
  - abort has priority over start in the same cycle.
- The asynchronous reset mid-operation returns everything to reset values immediately.

Test Plan:
- NBINS=4, pulse_total=1, din 10,20,30,40 after trig -> writes to addr 0..3 with data 10,20,30,40, each one cycle after its read; acc_ctrl=0; FLUSH -> READOUT with rdout_req=1; ack -> done pulse, pulse_cnt=1.
- pulse_total=3, each pulse din=5 per bin -> final writes 15 in every bin; acc_ctrl 0,1,1 across the pulses; exactly 12 writes total.
- ACC_W=17, DATA_W=16, pulse_total=3, din=0xFFFF -> third write saturates at 0x1FFFF and sat_flag=1; the flag clears on the next start.
- din_valid toggling 1,0,1,0 in ACQ -> writes only follow valid samples and addresses stay contiguous; trig in mid-ACQ -> trig_miss=1 with no effect on the sequence.
- abort during pulse 2 of 3 -> IDLE next cycle, no done, no further writes; start with pulse_total=0 -> one pulse, then READOUT.
- rst asserted mid-ACQ -> all outputs 0 asynchronously; rdout_ack in IDLE and start while busy have no effect.
